// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Memory-stage load/store engine sitting after the EX/MEM register. Issues
//   one outstanding req/ack access on the data bus, stalls upstream stages
//   until it completes, and returns sign/zero-extended load data.
//
// Ports
//   clk_EXMem, rst_EXMem      : clock (rising) / async active-high reset
//   valid_in, load_in         : live slot, instruction is a load
//   we_mask_in[3:0]           : lane byte enables, nonzero = store
//   Half_in/Byte_in/Sign_in   : access size and load sign extension
//   addr_in, wdata_in         : effective address, lane-aligned store data
//   mem_req/we/addr/wdata     : registered bus request
//   mem_ack, mem_rdata        : bus completion and read word
//   stall                     : combinational upstream hold
//   load_data, load_valid     : extended load result and its 1-cycle pulse
//   fault                     : 1-cycle pulse on misalignment or timeout
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk_EXMem,
   input  logic        rst_EXMem,
   input  logic        valid_in,
   input  logic        load_in,
   input  logic [3:0]  we_mask_in,
   input  logic        Half_in,
   input  logic        Byte_in,
   input  logic        Sign_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   output logic        mem_req,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        fault
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [4:0] CNT_LAST = 5'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [4:0]  cnt;
   logic [1:0]  off_q;
   logic        half_q, byte_q, sign_q, is_load_q;

   logic        is_store, is_access, misaligned, start, timeout_hit;
   logic [31:0] shifted, ext;

   assign is_store  = |we_mask_in;
   assign is_access = valid_in & (load_in | is_store);

   // Byte accesses can sit in any lane; halves may not straddle the word.
   always_comb begin
      misaligned = 1'b0;
      if (Byte_in)      misaligned = 1'b0;
      else if (Half_in) misaligned = (addr_in[1:0] == 2'b11);
      else              misaligned = (addr_in[1:0] != 2'b00);
   end

   assign start       = (state == IDLE) & is_access & ~misaligned;
   assign timeout_hit = (state == BUSY) & ~mem_ack & (cnt == CNT_LAST);
   assign stall       = start | ((state == BUSY) & ~mem_ack & ~timeout_hit);

   // Shifting by the latched byte offset lines the addressed lane(s) up at
   // bit 0; word accesses are always offset 0, so shifted is the raw word.
   assign shifted = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      ext = shifted;
      if (byte_q)
         ext = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      else if (half_q)
         ext = {{16{sign_q & shifted[15]}}, shifted[15:0]};
   end

   always_ff @(posedge clk_EXMem or posedge rst_EXMem) begin
      if (rst_EXMem) begin
         state      <= IDLE;
         cnt        <= '0;
         mem_req    <= 1'b0;
         mem_we     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         load_data  <= '0;
         load_valid <= 1'b0;
         fault      <= 1'b0;
         off_q      <= '0;
         half_q     <= 1'b0;
         byte_q     <= 1'b0;
         sign_q     <= 1'b0;
         is_load_q  <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         fault      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mem_addr  <= {addr_in[31:2], 2'b00};
                  // Store wins when both load_in and a write mask are present.
                  mem_we    <= is_store ? we_mask_in : 4'b0000;
                  mem_wdata <= wdata_in;
                  off_q     <= addr_in[1:0];
                  half_q    <= Half_in;
                  byte_q    <= Byte_in;
                  sign_q    <= Sign_in;
                  is_load_q <= ~is_store;
                  mem_req   <= 1'b1;
                  cnt       <= '0;
                  state     <= BUSY;
               end else if (is_access & misaligned) begin
                  fault <= 1'b1;
               end
            end
            BUSY: begin
               // ack is checked first so a last-cycle ack completes normally.
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
                  if (is_load_q) begin
                     load_data  <= ext;
                     load_valid <= 1'b1;
                  end
               end else if (cnt == CNT_LAST) begin
                  mem_req   <= 1'b0;
                  fault     <= 1'b1;
                  load_data <= '0;
                  state     <= IDLE;
               end else if (cnt != 5'h1F) begin
                  cnt <= cnt + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
